// File: rtl/hazard_scoreboard.sv
// Register-scoreboard hazard unit beside ID: per-register forwarding countdowns,
// mult/div busy timer, CP0 flush merging and a saturating stall-cycle counter.
module hazard_scoreboard #(
    parameter int NUM_REGS    = 32,
    parameter int ADDR_W      = 5,
    parameter int T_W         = 3,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid_i,
    input  logic [ADDR_W-1:0] rs_addr_i,
    input  logic [ADDR_W-1:0] rt_addr_i,
    input  logic [T_W-1:0]    tuse_rs_i,
    input  logic [T_W-1:0]    tuse_rt_i,
    input  logic [ADDR_W-1:0] dest_addr_i,
    input  logic [T_W-1:0]    tnew_id_i,
    input  logic              id_is_md_i,
    input  logic              md_start_i,
    input  logic              md_is_div_i,
    input  logic              flush_i,
    output logic              stall_pc_o,
    output logic              stall_id_o,
    output logic              clr_id_o,
    output logic              clr_ex_o,
    output logic              clr_mem_o,
    output logic              clr_wb_o,
    output logic              md_busy_o,
    output logic [CNT_W-1:0]  stall_cycles_o
);

    localparam int MD_MAX = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int MD_W   = $clog2(MD_MAX + 1);

    logic [T_W-1:0]   sb_q [NUM_REGS];
    logic [T_W-1:0]   sb_d [NUM_REGS];
    logic [MD_W-1:0]  md_cnt_q, md_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic stall_rs, stall_rt, stall_md, stall, hold, issue, md_busy;

    // Hazard decision straight from registered state; sb[0] is held at zero.
    always_comb begin
        stall_rs = id_valid_i && (rs_addr_i != '0) && (sb_q[rs_addr_i] > tuse_rs_i);
        stall_rt = id_valid_i && (rt_addr_i != '0) && (sb_q[rt_addr_i] > tuse_rt_i);
        md_busy  = md_start_i || (md_cnt_q != '0);
        stall_md = id_valid_i && id_is_md_i && md_busy;
        stall    = stall_rs || stall_rt || stall_md;
        hold     = stall && !flush_i;
        issue    = id_valid_i && !stall && !flush_i;
    end

    // Flush beats issue, and issue beats the per-cycle decrement of its entry.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            sb_d[i] = (sb_q[i] != '0) ? sb_q[i] - T_W'(1) : '0;
        end
        if (issue && (dest_addr_i != '0)) begin
            sb_d[dest_addr_i] = (tnew_id_i == '0) ? '0 : tnew_id_i - T_W'(1);
        end
        if (flush_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                sb_d[i] = '0;
            end
        end
        sb_d[0] = '0;
    end

    // A started mult/div always runs to completion, even across a flush.
    always_comb begin
        if (md_start_i) begin
            md_cnt_d = md_is_div_i ? MD_W'(DIV_CYCLES) : MD_W'(MULT_CYCLES);
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - MD_W'(1);
        end else begin
            md_cnt_d = '0;
        end
        stall_cnt_d = (hold && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                sb_q[i] <= '0;
            end
            md_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                sb_q[i] <= sb_d[i];
            end
            md_cnt_q    <= md_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Reset forces the pipeline into a cleared, non-holding state.
    assign stall_pc_o     = !reset && hold;
    assign stall_id_o     = !reset && hold;
    assign clr_ex_o       = reset || hold || flush_i;
    assign clr_id_o       = reset || flush_i;
    assign clr_mem_o      = reset || flush_i;
    assign clr_wb_o       = reset || flush_i;
    assign md_busy_o      = !reset && md_busy;
    assign stall_cycles_o = stall_cnt_q;

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard-control unit that sits beside the ID stage of the five-stage CPU. It replaces per-stage Tnew/address comparison with a register scoreboard: one countdown entry per architectural register, holding the cycles until the pending result can be forwarded. It also owns a cycle-accurate multiply/divide busy timer with per-operation latency, merges CP0 flush requests, and keeps a saturating stall-cycle performance counter.

## Interface
- NUM_REGS, 32, number of architectural registers; register 0 is hard-wired zero and never tracked.
- ADDR_W, 5, register address width; ceil(log2(NUM_REGS)).
- T_W, 3, width of Tuse/Tnew values; all-ones means TUSE_INF, i.e. never used.
- MULT_CYCLES, 5, busy cycles loaded for MULT/MULTU.
- DIV_CYCLES, 10, busy cycles loaded for DIV/DIVU.
- CNT_W, 32, stall-counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous reset, active-high.
- id_valid  in  1  ID holds a real instruction; 0 for a bubble.
- rs_addr, rt_addr  in  ADDR_W  source registers of the ID instruction.
- tuse_rs, tuse_rt  in  T_W  Tuse per source.
- dest_addr  in  ADDR_W  destination register of the ID instruction; 0 means none.
- tnew_id  in  T_W  Tnew of the ID instruction, measured at ID.
- id_is_md  in  1  ID instruction uses the mult/div unit.
- md_start  in  1  mult/div operation starts in EX this cycle.
- md_is_div  in  1  qualifies md_start: 1 selects DIV_CYCLES, 0 selects MULT_CYCLES.
- flush  in  1  CP0 KTEXT/ERET flush request.
- stall_pc, stall_id  out  1  hold PC and the IF/ID register.
- clr_id, clr_ex, clr_mem, clr_wb  out  1  clear pipeline registers.
- md_busy  out  1  mult/div unit occupied.
- stall_cycles  out  CNT_W  count of stalled cycles.

## Operation
Scoreboard:
- sb[1..NUM_REGS-1] are T_W-bit counters. sb[0] reads as 0.
- An issue occurs when id_valid & !stall & !flush.
- Each edge, every nonzero entry decrements by 1, saturating at 0.
- On issue with dest_addr != 0: sb[dest_addr] <= (tnew_id == 0) ? 0 : tnew_id - 1. This overrides that entry's decrement in the same cycle.
- flush: all entries <= 0 at the edge; this takes priority over issue and decrement.

Stall logic (combinational from registered state):
- stall_rs = id_valid & rs_addr != 0 & sb[rs_addr] > tuse_rs.
- stall_rt is the same check using rt_addr and tuse_rt.
- A tuse of TUSE_INF never stalls, because sb is at most 2^T_W - 2.

Mult/div timer:
- On md_start, md_cnt <= md_is_div ? DIV_CYCLES : MULT_CYCLES. A start while busy restarts the timer.
- Otherwise md_cnt decrements while nonzero.
- A flush does not affect md_cnt: an operation already started runs to completion.
- md_busy = md_start | (md_cnt != 0).
- stall_md = id_valid & id_is_md & md_busy.

Merged outputs:
- stall = stall_rs | stall_rt | stall_md.
- stall_pc = stall_id = stall & !flush.
- clr_ex = (stall & !flush) | flush.
- clr_id = clr_mem = clr_wb = flush.

Stall counter:
- Increments when stall & !flush.
- Saturates at all-ones.

Reset:
- All sb entries, md_cnt and stall_cycles are cleared to 0.
- While reset is high: stall_pc = stall_id = 0, all clr_* = 1, md_busy = 0.

## Timing
- Scoreboard lookup and stall decision are zero-latency combinational paths from the registered sb array.
- An issue at edge k is first visible to the instruction in ID during cycle k+1.
- Example, lw with tnew_id = 3 issued at edge 0:
  - sb = 2 in cycle 1, when the lw is in EX.
  - sb = 1 in cycle 2, when the lw is in MEM.
  - sb = 0 in cycle 3.
  - A consumer with tuse = 1 stalls exactly 1 cycle.
- Mult/div: md_busy is high in the md_start cycle plus the following N cycles, where N = MULT_CYCLES or DIV_CYCLES.
- Simultaneous flush and stall: the flush wins. No hold; all stages are cleared.
- Simultaneous issue and decrement of the same entry: the issue value wins.

## Test plan
- lw $1 (tnew_id = 3, dest = 1), then addu using rs = 1 (tuse = 1) -> stall_pc/stall_id/clr_ex high for exactly 1 cycle; stall_cycles = 1.
- lw $1, then beq using rs = 1 (tuse = 0) -> 2 consecutive stall cycles; then no stall.
- Producer with dest_addr = 0, then consumer reading $0 -> no stall, and sb stays all zero.
- md_start with md_is_div = 1 (DIV_CYCLES = 10), then mflo in ID (id_is_md = 1) -> stall for 10 cycles after the start cycle; released when md_cnt reaches 0.
- Pending lw $2 (sb[2] = 2) with a stalled consumer, and flush asserted -> stall_pc = 0, all clr_* = 1, sb[2] = 0 next cycle; a re-fetched consumer is not stalled.
- Counter preloaded near saturation with continuous stall -> stall_cycles holds at 2^CNT_W - 1. Asserting reset mid-division -> md_busy = 0 and stall_cycles = 0 after the edge.
